// File: rtl/mem_read_ctrl.sv
// Load-side RAM read sequencer: splits byte/half/word loads into 8-bit RAM reads and assembles them little-endian.
// Optional macro MEM_READ_CTRL_ABORT_EN: a request dropped to 00 while reading aborts the read.
module mem_read_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_size_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic [31:0]       data_o,
    output logic              data_valid_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_a_o,
    input  logic [7:0]        mem_din_i,
    output logic              mem_wr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        n_r;
    logic [2:0]        k_r;
    logic [1:0]        j_r;
    logic              a_live_r;
    logic              d_live_r;
    logic [31:0]       asm_r;

    logic [2:0]        n_req_s;
    logic [31:0]       asm_next_s;
    logic              last_s;
    logic              abort_s;

    assign mem_wr_o = 1'b0;
    assign last_s   = ({1'b0, j_r} == (n_r - 3'd1));

`ifdef MEM_READ_CTRL_ABORT_EN
    assign abort_s = (req_size_i == 2'b00);
`else
    assign abort_s = 1'b0;
`endif

    // Byte count of the incoming request.
    always_comb begin
        n_req_s = 3'd0;
        case (req_size_i)
            2'b01:   n_req_s = 3'd1;
            2'b10:   n_req_s = 3'd2;
            2'b11:   n_req_s = 3'd4;
            default: n_req_s = 3'd0;
        endcase
    end

    // Assembly word with the arriving RAM byte placed in lane j.
    always_comb begin
        asm_next_s = asm_r;
        case (j_r)
            2'd0:    asm_next_s[7:0]   = mem_din_i;
            2'd1:    asm_next_s[15:8]  = mem_din_i;
            2'd2:    asm_next_s[23:16] = mem_din_i;
            2'd3:    asm_next_s[31:24] = mem_din_i;
            default: asm_next_s = asm_r;
        endcase
    end

    // Sequencer: a_live marks an address on the RAM this cycle, d_live marks its byte arriving.
    // Completion is folded into the last capture edge so busy drops and a new request is accepted in the pulse cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            n_r          <= 3'd0;
            k_r          <= 3'd0;
            j_r          <= 2'd0;
            a_live_r     <= 1'b0;
            d_live_r     <= 1'b0;
            asm_r        <= 32'd0;
            data_o       <= 32'd0;
            data_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            mem_a_o      <= {ADDR_W{1'b0}};
        end else begin
            data_valid_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_size_i != 2'b00) begin
                        addr_r   <= req_addr_i;
                        n_r      <= n_req_s;
                        asm_r    <= 32'd0;
                        mem_a_o  <= req_addr_i;
                        k_r      <= 3'd1;
                        j_r      <= 2'd0;
                        a_live_r <= 1'b1;
                        d_live_r <= 1'b0;
                        busy_o   <= 1'b1;
                        state_r  <= READ;
                    end else begin
                        a_live_r <= 1'b0;
                        d_live_r <= 1'b0;
                    end
                end
                READ: begin
                    if (abort_s) begin
                        a_live_r <= 1'b0;
                        d_live_r <= 1'b0;
                        busy_o   <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        d_live_r <= a_live_r;
                        if (k_r < n_r) begin
                            mem_a_o  <= addr_r + ADDR_W'(k_r);
                            k_r      <= k_r + 3'd1;
                            a_live_r <= 1'b1;
                        end else begin
                            a_live_r <= 1'b0;
                        end
                        if (d_live_r) begin
                            asm_r <= asm_next_s;
                            j_r   <= j_r + 2'd1;
                            if (last_s) begin
                                data_o       <= asm_next_s;
                                data_valid_o <= 1'b1;
                                busy_o       <= 1'b0;
                                state_r      <= IDLE;
                            end else begin
                                state_r <= READ;
                            end
                        end else begin
                            state_r <= READ;
                        end
                    end
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Scoreboard bench for mem_read_ctrl: directed loads, expected data/cycle queued at issue, checked by a monitor.
module tb_mem_read_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_size;
    logic [16:0] req_addr;
    logic [31:0] data;
    logic        data_valid;
    logic        busy;
    logic [16:0] mem_a;
    logic [7:0]  mem_din;
    logic        mem_wr;

    mem_read_ctrl #(.ADDR_W(17)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_size_i   (req_size),
        .req_addr_i   (req_addr),
        .data_o       (data),
        .data_valid_o (data_valid),
        .busy_o       (busy),
        .mem_a_o      (mem_a),
        .mem_din_i    (mem_din),
        .mem_wr_o     (mem_wr)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:131071];
    always @(posedge clk) mem_din <= ram[mem_a];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation in data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pulse data %h at cycle %0d expected none", data, cyc);
            end else begin
                e = sb.pop_front();
                check("data", data, e.data);
                check("valid_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic drive(input logic [1:0] size, input logic [16:0] addr,
                         input logic [31:0] exp, input bit push);
        int lat;
        lat = (size == 2'b01) ? 3 : (size == 2'b10) ? 4 : 6;
        req_size = size;
        req_addr = addr;
        if (push) sb.push_back('{exp, cyc + lat});
    endtask

    // Checks the address sequence, waits for the pulse, then drops or replaces the request.
    task automatic follow(input int n, input logic [16:0] addr, input logic [1:0] nsize,
                          input logic [16:0] naddr, input logic [31:0] nexp);
        logic [16:0] a;
        bit done;
        done = 1'b0;
        for (int m = 1; m <= 20 && !done; m++) begin
            @(negedge clk);
            if (m <= n) begin
                a = addr + 17'(m - 1);
                check("mem_a", 32'(mem_a), 32'(a));
            end
            if (data_valid) begin
                done = 1'b1;
                if (nsize != 2'b00) drive(nsize, naddr, nexp, 1'b1);
                else req_size = 2'b00;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no valid pulse expected one for addr %h", addr);
        end
    endtask

    initial begin
        ram[17'h00100] = 8'h11; ram[17'h00101] = 8'h22;
        ram[17'h00102] = 8'h33; ram[17'h00103] = 8'h44;
        ram[17'h00005] = 8'hF0;
        ram[17'h00006] = 8'h34; ram[17'h00007] = 8'h12;
        ram[17'h1FFFE] = 8'hAA; ram[17'h1FFFF] = 8'hBB;
        ram[17'h00000] = 8'hCC; ram[17'h00001] = 8'hDD;
        ram[17'h00010] = 8'h5A; ram[17'h00011] = 8'hA5;
        ram[17'h00020] = 8'h7E;

        rst = 1'b1;
        req_size = 2'b00;
        req_addr = 17'h0;
        repeat (3) @(negedge clk);
        check("rst_data", data, 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mem_a", 32'(mem_a), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        rst = 1'b0;

        @(negedge clk); drive(2'b11, 17'h00100, 32'h44332211, 1'b1);
        follow(4, 17'h00100, 2'b00, 17'h0, 32'h0);
        @(negedge clk); drive(2'b01, 17'h00005, 32'h000000F0, 1'b1);
        follow(1, 17'h00005, 2'b00, 17'h0, 32'h0);
        @(negedge clk); drive(2'b10, 17'h00006, 32'h00001234, 1'b1);
        follow(2, 17'h00006, 2'b00, 17'h0, 32'h0);
        @(negedge clk); drive(2'b11, 17'h1FFFE, 32'hDDCCBBAA, 1'b1);
        follow(4, 17'h1FFFE, 2'b00, 17'h0, 32'h0);

        // Back-to-back: the byte read is presented in the half read's valid cycle.
        @(negedge clk); drive(2'b10, 17'h00010, 32'h0000A55A, 1'b1);
        follow(2, 17'h00010, 2'b01, 17'h00020, 32'h0000007E);
        follow(1, 17'h00020, 2'b00, 17'h0, 32'h0);

        // Reset in cycle 2 of a word read.
        @(negedge clk); drive(2'b11, 17'h00100, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk); rst = 1'b1; req_size = 2'b00;
        @(negedge clk);
        check("midrst_data", data, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_mem_a", 32'(mem_a), 32'h0);
        check("midrst_valid", 32'(data_valid), 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        drive(2'b01, 17'h00005, 32'h000000F0, 1'b1);
        follow(1, 17'h00005, 2'b00, 17'h0, 32'h0);

        // Request dropped in cycle 2 of a word read.
        @(negedge clk);
`ifdef MEM_READ_CTRL_ABORT_EN
        drive(2'b11, 17'h00100, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk); req_size = 2'b00;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_data", data, 32'h000000F0);
        repeat (6) @(negedge clk);
        check("abort_data_hold", data, 32'h000000F0);
`else
        drive(2'b11, 17'h00100, 32'h44332211, 1'b1);
        @(negedge clk);
        @(negedge clk); req_size = 2'b00;
        begin
            bit seen;
            seen = 1'b0;
            for (int m = 0; m < 10 && !seen; m++) begin
                @(negedge clk);
                if (data_valid) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL drop_complete: got no valid pulse expected one");
            end
        end
`endif

        repeat (3) @(negedge clk);
        check("pending_expect", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
